// File: rtl/matrix_spi_lane_tx_if.sv
// Word handshake between the frame-buffer readout and the SPI lane serializer.
//   in_data   LANES*8  lane i byte = in_data[8i+7:8i]
//   in_valid  1        in_data/in_last valid
//   in_last   1        word is the last of a frame
//   in_ready  1        serializer can take a word this cycle
// master: word source (frame-buffer readout); slave: matrix_spi_lane_tx.
interface matrix_spi_lane_tx_if #(
  parameter int LANES = 8
) ();
  logic [LANES*8-1:0] in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/matrix_spi_lane_tx.sv
// Parallel multi-lane SPI (mode 0) serializer for the LED matrix panel controllers.
// Every lane shifts its own byte out MSB-first on a shared spi_clk; a word tagged
// last is followed by an idle gap the panel controllers use to resync.
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus         word handshake (slave side): in_data, in_valid, in_last, in_ready
//   spi_clk     shared SPI clock, idles low
//   spi_mosi    per-lane serial data, MSB first
//   busy        high while shifting or in the frame gap
//   frame_done  one-cycle pulse after the frame gap ends
//
// state | meaning
// IDLE  | in_ready high, waiting for a word
// SHIFT | clocking 8 bits out on every lane, CLK_DIV cycles per clock phase
// GAP   | lines held low for GAP_CYCLES after the last word of a frame
module matrix_spi_lane_tx #(
  parameter int LANES      = 8,
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_spi_lane_tx_if.slave  bus,
  output logic                 spi_clk,
  output logic [LANES-1:0]     spi_mosi,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t             state;
  logic [LANES*8-1:0] shreg;
  logic               last_q;
  logic [2:0]         bit_cnt;
  logic               phase_high;
  logic [DIV_W-1:0]   div_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.in_ready <= 1'b0;
      spi_clk      <= 1'b0;
      spi_mosi     <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      shreg        <= '0;
      last_q       <= 1'b0;
      bit_cnt      <= '0;
      phase_high   <= 1'b0;
      div_cnt      <= '0;
      gap_cnt      <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          // in_ready is registered, so a word is only taken once ready is visible upstream
          if (bus.in_valid && bus.in_ready) begin
            shreg        <= bus.in_data;
            last_q       <= bus.in_last;
            bit_cnt      <= 3'd7;
            phase_high   <= 1'b0;
            div_cnt      <= '0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= SHIFT;
            for (int i = 0; i < LANES; i++) begin
              spi_mosi[i] <= bus.in_data[8*i+7];
            end
          end else begin
            bus.in_ready <= 1'b1;
          end
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!phase_high) begin
              phase_high <= 1'b1;
              spi_clk    <= 1'b1;
            end else begin
              phase_high <= 1'b0;
              spi_clk    <= 1'b0;
              if (bit_cnt != 3'd0) begin
                bit_cnt <= bit_cnt - 3'd1;
                // bit 7 is already on the line, so the next bit out is bit 6
                for (int i = 0; i < LANES; i++) begin
                  spi_mosi[i]      <= shreg[8*i+6];
                  shreg[8*i +: 8]  <= {shreg[8*i +: 7], 1'b0};
                end
              end else begin
                spi_mosi <= '0;
                gap_cnt  <= '0;
                if (last_q) begin
                  state <= GAP;
                end else begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  bus.in_ready <= 1'b1;
                end
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt      <= '0;
            state        <= IDLE;
            busy         <= 1'b0;
            bus.in_ready <= 1'b1;
            frame_done   <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          bus.in_ready <= 1'b0;
          spi_clk      <= 1'b0;
          spi_mosi     <= '0;
        end
      endcase
    end
  end

endmodule
